// File: rtl/timer_pkg.sv
// timer_pkg: shared timer types and defaults
package timer_pkg;
  localparam int CNT_W_DEFAULT = 16;
  typedef enum logic [1:0] {OM_HOLD, OM_TOGGLE, OM_PWM, OM_ONEPULSE} out_mode_e;
endpackage

// File: rtl/compare_channel.sv
// compare_channel: one comparator with shadow/active compare value, edge detect and sticky flag
module compare_channel #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             update,
  input  logic             wr_en,
  input  logic             flag_clr,
  input  logic [CNT_W-1:0] counter_value,
  input  logic [CNT_W-1:0] wr_data,
  output logic             match,
  output logic             rise,
  output logic             flag
);
  logic [CNT_W-1:0] shadow, active;
  logic match_past;
  assign match = active == counter_value;
  assign rise = match & ~match_past & en;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shadow <= '1;
      active <= '1;
      match_past <= 1'b1;
      flag <= 1'b0;
    end else begin
      if (wr_en) shadow <= wr_data;
      // a write landing with the update (or while stopped) bypasses the shadow
      if (wr_en && (!en || update)) active <= wr_data;
      else if (en && update) active <= shadow;
      match_past <= match;
      flag <= rise | (flag & ~flag_clr);
    end
  end
endmodule

// File: rtl/timer_compare_output.sv
// timer_compare_output: compare/output stage with per-channel hold/toggle/PWM/one-pulse modes
module timer_compare_output
  import timer_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEFAULT,
  parameter int NUM_OUT = 2,
  localparam int NUM_COMP = 2 * NUM_OUT
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic [CNT_W-1:0]          counter_value,
  input  logic                      update,
  input  logic [NUM_COMP-1:0]       cmp_wr_en,
  input  logic [NUM_COMP*CNT_W-1:0] cmp_wr_data,
  input  logic [NUM_OUT*2-1:0]      mode,
  input  logic [NUM_OUT-1:0]        inv,
  input  logic [NUM_OUT-1:0]        rearm,
  input  logic [NUM_COMP-1:0]       intr_en,
  input  logic [NUM_COMP-1:0]       trg_en,
  input  logic [NUM_COMP-1:0]       flag_clr,
  output logic [NUM_OUT-1:0]        timer_out,
  output logic [NUM_COMP-1:0]       match,
  output logic [NUM_COMP-1:0]       flag,
  output logic [NUM_COMP-1:0]       intr,
  output logic                      trigger
);
  logic [NUM_COMP-1:0] rise;
  logic [NUM_OUT-1:0] state, state_nx, armed, armed_nx;
  for (genvar i = 0; i < NUM_COMP; i++) begin : g_cmp
    compare_channel #(.CNT_W(CNT_W)) u_cmp (
      .clk(clk),
      .rst(rst),
      .en(en),
      .update(update),
      .wr_en(cmp_wr_en[i]),
      .flag_clr(flag_clr[i]),
      .counter_value(counter_value),
      .wr_data(cmp_wr_data[i*CNT_W +: CNT_W]),
      .match(match[i]),
      .rise(rise[i]),
      .flag(flag[i])
    );
  end
  assign intr = flag & intr_en;
  assign timer_out = state ^ inv;
  always_comb begin
    state_nx = state;
    armed_nx = armed;
    for (int k = 0; k < NUM_OUT; k++) begin
      unique case (out_mode_e'(mode[2*k +: 2]))
        OM_TOGGLE: state_nx[k] = state[k] ^ rise[2*k];
        OM_PWM: state_nx[k] = rise[2*k] | (state[k] & ~rise[2*k+1]);
        OM_ONEPULSE: state_nx[k] = ~rise[2*k+1] & (state[k] | (rise[2*k] & armed[k]));
        default: state_nx[k] = state[k];
      endcase
      armed_nx[k] = rearm[k] | (armed[k] & ~(rise[2*k+1] & (mode[2*k +: 2] == OM_ONEPULSE)));
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= '0;
      armed <= '1;
      trigger <= 1'b0;
    end else begin
      state <= state_nx;
      armed <= armed_nx;
      trigger <= |(rise & trg_en);
    end
  end
endmodule

// File: tb/tb_timer_compare_output.sv
// tb_timer_compare_output: table, directed and randomized checks against a behavioural model
module tb_timer_compare_output;
  logic clk = 1'b0;
  logic rst, en, update, trigger;
  logic [15:0] cv;
  logic [3:0] wr_en, intr_en, trg_en, flag_clr, match, flag, intr;
  logic [63:0] wr_data;
  logic [3:0] mode;
  logic [1:0] inv, rearm, timer_out;
  int n_cmp = 0, n_bad = 0;

  timer_compare_output #(.CNT_W(16), .NUM_OUT(2)) dut (
    .clk(clk), .rst(rst), .en(en), .counter_value(cv), .update(update),
    .cmp_wr_en(wr_en), .cmp_wr_data(wr_data), .mode(mode), .inv(inv),
    .rearm(rearm), .intr_en(intr_en), .trg_en(trg_en), .flag_clr(flag_clr),
    .timer_out(timer_out), .match(match), .flag(flag), .intr(intr), .trigger(trigger)
  );

  always #5 clk = ~clk;

  logic [15:0] sh[4], ac[4];
  bit mp[4], fl[4], st[2], ar[2], tg;

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t cv=%0d)", nm, a, e, $time, cv);
    end
  endtask

  task automatic mreset();
    for (int i = 0; i < 4; i++) begin
      sh[i] = 16'hFFFF; ac[i] = 16'hFFFF; mp[i] = 1; fl[i] = 0;
    end
    st = '{0, 0}; ar = '{1, 1}; tg = 0;
  endtask

  task automatic cyc();
    logic [3:0] em, ef;
    logic [1:0] eo;
    bit r[4];
    #1;
    for (int i = 0; i < 4; i++) begin
      em[i] = ac[i] == cv;
      ef[i] = fl[i];
    end
    for (int k = 0; k < 2; k++) eo[k] = st[k] ^ inv[k];
    chk("match", match, em);
    chk("flag", flag, ef);
    chk("intr", intr, ef & intr_en);
    chk("timer_out", timer_out, eo);
    chk("trigger", trigger, tg);
    tg = 0;
    for (int i = 0; i < 4; i++) begin
      r[i] = em[i] && !mp[i] && en;
      if (r[i] && trg_en[i]) tg = 1;
      if (r[i]) fl[i] = 1;
      else if (flag_clr[i]) fl[i] = 0;
    end
    for (int k = 0; k < 2; k++) begin
      case (mode[2*k +: 2])
        2'b01: if (r[2*k]) st[k] = !st[k];
        2'b10: if (r[2*k]) st[k] = 1; else if (r[2*k+1]) st[k] = 0;
        2'b11: if (r[2*k+1]) st[k] = 0; else if (r[2*k] && ar[k]) st[k] = 1;
        default: ;
      endcase
      if (mode[2*k +: 2] == 2'b11 && r[2*k+1]) ar[k] = 0;
      if (rearm[k]) ar[k] = 1;
    end
    for (int i = 0; i < 4; i++) begin
      if (wr_en[i] && (!en || update)) ac[i] = wr_data[16*i +: 16];
      else if (en && update) ac[i] = sh[i];
      if (wr_en[i]) sh[i] = wr_data[16*i +: 16];
      mp[i] = em[i];
    end
    @(negedge clk);
  endtask

  task automatic at(input logic [15:0] v);
    cv = v;
    cyc();
  endtask

  task automatic wr_stopped(input int i, input logic [15:0] v);
    logic e0;
    e0 = en;
    en = 0;
    wr_en = 4'b0001 << i;
    wr_data[16*i +: 16] = v;
    cyc();
    wr_en = 0;
    en = e0;
  endtask

  // one counter period 0..n-1 with update at the wrap; optional write and rearm pulse
  task automatic period(input int n, input int wi, input int wc, input logic [15:0] wv,
                        input int rc, output int hi);
    hi = 0;
    for (int c = 0; c < n; c++) begin
      cv = 16'(c);
      update = c == n - 1;
      wr_en = (c == wc) ? (4'b0001 << wi) : 4'b0;
      if (c == wc) wr_data[16*wi +: 16] = wv;
      rearm = (c == rc) ? 2'b01 : 2'b00;
      #1 hi += int'(timer_out[0]);
      cyc();
    end
    update = 0; wr_en = 0; rearm = 0;
  endtask

  typedef struct {
    logic [15:0] cnt;
    logic [1:0] out;
    logic [3:0] flg;
    logic [3:0] mat;
  } row_t;
  row_t tbl[9];

  initial begin
    int hi;
    tbl[0] = '{8, 2'b00, 4'b0000, 4'b0000};
    tbl[1] = '{9, 2'b00, 4'b0000, 4'b0000};
    tbl[2] = '{10, 2'b00, 4'b0000, 4'b0001};
    tbl[3] = '{11, 2'b01, 4'b0001, 4'b0000};
    tbl[4] = '{12, 2'b01, 4'b0001, 4'b0000};
    tbl[5] = '{29, 2'b01, 4'b0001, 4'b0000};
    tbl[6] = '{30, 2'b01, 4'b0001, 4'b0010};
    tbl[7] = '{31, 2'b00, 4'b0011, 4'b0000};
    tbl[8] = '{32, 2'b00, 4'b0011, 4'b0000};
    rst = 0; en = 0; update = 0; cv = 0; wr_en = 0; wr_data = 0; mode = 0;
    inv = 0; rearm = 0; intr_en = 0; trg_en = 0; flag_clr = 0;
    mreset();
    repeat (2) @(negedge clk);
    #1;
    chk("rst_timer_out", timer_out, 2'b00);
    chk("rst_flag", flag, 4'b0000);
    chk("rst_trigger", trigger, 1'b0);
    chk("rst_match", match, 4'b0000);
    @(negedge clk);
    rst = 1;
    wr_stopped(0, 10);
    wr_stopped(1, 30);
    mode = 4'b0010;
    en = 1;
    for (int j = 0; j < 9; j++) begin
      cv = tbl[j].cnt;
      #1;
      chk("tbl_out", timer_out, tbl[j].out);
      chk("tbl_flag", flag, tbl[j].flg);
      chk("tbl_match", match, tbl[j].mat);
      chk("tbl_intr", intr, 4'b0000);
      cyc();
    end
    period(100, 1, 40, 50, -1, hi); chk("shadow_before_update", hi, 20);
    period(100, 1, 99, 70, -1, hi); chk("shadow_after_update", hi, 40);
    period(100, 0, -1, 0, -1, hi); chk("write_with_update", hi, 60);
    wr_stopped(0, 5);
    wr_stopped(1, 8);
    mode = 4'b0011;
    period(16, 0, -1, 0, -1, hi); chk("onepulse_first", hi, 3);
    period(16, 0, -1, 0, -1, hi); chk("onepulse_disarmed", hi, 0);
    period(16, 0, -1, 0, 0, hi); chk("onepulse_rearm", hi, 3);
    period(16, 0, -1, 0, 8, hi); chk("onepulse_rearm_with_c", hi, 0);
    period(16, 0, -1, 0, -1, hi); chk("onepulse_still_armed", hi, 3);
    wr_stopped(0, 20);
    wr_stopped(1, 20);
    mode = 4'b0010;
    period(32, 0, -1, 0, -1, hi); chk("pwm_equal_first", hi, 11);
    period(32, 0, -1, 0, -1, hi); chk("pwm_equal_full", hi, 32);
    mode = 4'b0011;
    period(32, 0, -1, 0, 0, hi); chk("onepulse_equal_clear", hi, 21);
    period(32, 0, -1, 0, -1, hi); chk("onepulse_equal_disarm", hi, 0);
    mode = 4'b0010;
    wr_stopped(0, 10);
    wr_stopped(1, 30);
    trg_en = 4'b0010; intr_en = 4'b0001;
    flag_clr = 4'hF; at(0); flag_clr = 0;
    at(9); at(10);
    chk("intr_after_rise", intr, 4'b0001);
    chk("trigger_not_enabled", trigger, 1'b0);
    at(29); at(30);
    chk("trigger_pulse", trigger, 1'b1);
    at(31);
    chk("trigger_one_cycle", trigger, 1'b0);
    flag_clr = 4'b0001;
    at(0);
    chk("flag_cleared", flag[0], 1'b0);
    at(10);
    flag_clr = 0;
    chk("flag_set_wins", flag[0], 1'b1);
    inv = 2'b10;
    at(11);
    chk("pre_reset_out", timer_out, 2'b11);
    #2 rst = 0;
    #1;
    chk("async_rst_out", timer_out, 2'b10);
    chk("async_rst_flag", flag, 4'b0000);
    cv = 16'hFFFF;
    #1 chk("async_rst_active", match, 4'hF);
    @(negedge clk);
    rst = 1;
    mreset();
    at(16'hFFFF); at(16'hFFFF);
    chk("release_no_flag", flag, 4'b0000);
    chk("release_out", timer_out, 2'b10);
    for (int i = 0; i < 4; i++) wr_stopped(i, 16'($urandom_range(0, 47)));
    for (int p = 0; p < 30; p++) begin
      mode = 4'($urandom);
      if ($urandom_range(0, 3) == 0) inv = 2'($urandom);
      for (int c = 0; c < 48; c++) begin
        cv = 16'(c);
        update = c == 47;
        en = $urandom_range(0, 19) != 0;
        for (int i = 0; i < 4; i++) begin
          wr_en[i] = $urandom_range(0, 15) == 0;
          wr_data[16*i +: 16] = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom_range(0, 47));
          flag_clr[i] = $urandom_range(0, 7) == 0;
          intr_en[i] = $urandom_range(0, 1) == 1;
          trg_en[i] = $urandom_range(0, 1) == 1;
        end
        rearm = ($urandom_range(0, 15) == 0) ? 2'($urandom) : 2'b00;
        cyc();
      end
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/timer_compare_output.md
Name: timer_compare_output

Overview:
Parametrised next-generation compare/output stage of the timer, replacing the fixed 8-bit, 3-comparator output stage.
- Counter width and output-channel count are parameters; each output channel owns a pair of comparators.
- New features: double-buffered (shadow) compare registers, a per-channel output mode (toggle, PWM, one-pulse), sticky interrupt flags and a registered trigger.
- Sits between the timer counter/prescaler and the register interface; drives the timer pins.

Parameters:
CNT_W, 16, counter and compare width in bits.
NUM_OUT, 2, number of output channels.
NUM_COMP, 2*NUM_OUT, comparators; fixed by construction. Channel k uses comp 2k (set) and 2k+1 (clear).

Ports:
clk  in  1  timer clock.
rst  in  1  reset. One clock; reset is asynchronous and active-low.
en  in  1  timer enable.
counter_value  in  CNT_W  running counter.
update  in  1  counter wrap/update-event pulse.
cmp_wr_en  in  NUM_COMP  per-comparator shadow write strobe.
cmp_wr_data  in  NUM_COMP*CNT_W  shadow write data, packed by comparator.
mode  in  NUM_OUT*2  per-channel mode: 00 hold, 01 toggle, 10 PWM, 11 one-pulse.
inv  in  NUM_OUT  per-channel output inversion.
rearm  in  NUM_OUT  one-pulse re-arm pulse.
intr_en  in  NUM_COMP  interrupt enable.
trg_en  in  NUM_COMP  trigger enable.
flag_clr  in  NUM_COMP  write-1-to-clear for flags.
timer_out  out  NUM_OUT  channel outputs.
match  out  NUM_COMP  combinational: active[i] == counter_value.
flag  out  NUM_COMP  sticky match flags.
intr  out  NUM_COMP  flag & intr_en (combinational).
trigger  out  1  registered pulse, OR over comparators.

Behaviour:
- Reset (rst low, async): shadow and active registers = all-ones; match_past = all-ones (suppresses a spurious rise at reset release); flag = 0; trigger = 0; internal out state = 0; armed = all-ones. timer_out = inv (internal 0, inverted).
- Shadow write: cmp_wr_en[i] loads shadow[i] at clk.
- Active update:
  - en=0: active[i] loads together with the shadow write, on the same edge.
  - en=1: active <= shadow on update.
  - Write and update in the same cycle: active takes the new write data.
- Edge detect: rise[i] = match[i] & ~match_past[i] & en. match_past registered every cycle, regardless of en.
- Flags: flag[i] set on rise[i]; cleared by flag_clr[i]. Set and clear in the same cycle -> set wins.
- Trigger: trigger <= |(rise & trg_en), so it is high exactly one cycle after the rise cycle.
- Output channel k, with S = rise[2k] and C = rise[2k+1]; internal state updates on the edge after the rise cycle (1-cycle latency):
  - 00 hold: state unchanged.
  - 01 toggle: S toggles the state; C is ignored.
  - 10 PWM: S sets, C clears. S and C together -> set wins (equal compares give 100% duty).
  - 11 one-pulse: S sets only if armed. C clears and disarms (armed=0). rearm sets armed. S and C together while armed -> state stays 0 and the channel disarms. rearm together with C -> armed stays 1.
- Mode change mid-run: internal state is kept, never reset; the new mode applies from the next rise.
- timer_out[k] = state[k] ^ inv[k] (combinational).
- Wrap-around: a compare value equal to the wrap point matches normally. A compare value the counter never reaches never produces a rise.
- en low: no rises, flags and outputs hold, shadow writes still accepted.

Decomposition:
- Add to timer_pkg:
  - out_mode_e enum (OM_HOLD, OM_TOGGLE, OM_PWM, OM_ONEPULSE).
  - CNT_W default constant.
- Sub-module compare_channel: holds shadow, active, compare, match_past, rise and flag for one comparator; instantiated NUM_COMP times.
- Top level holds the channel output state machines, the armed bits and trigger.

Test Plan:
1. PWM duty: CNT_W=16, en=1, mode0=10, comp0=10, comp1=30, counter 0..99 with update at wrap -> timer_out[0] rises at the edge after counter=10 and falls at the edge after counter=30; flag[0] and flag[1] set; intr=0 while intr_en=0.
2. Shadow update: while running, write comp1=50 mid-period -> duty unchanged until update; next period falls after counter=50. Repeat with write and update coincident -> new value active that period.
3. One-pulse: mode0=11, comp0=5, comp1=8, two periods -> single pulse 5..8 only; assert rearm -> pulse repeats next period; rearm and C coincident -> armed stays 1.
4. Simultaneous set/clear: comp0=comp1=20 -> PWM output stays 1; one-pulse output stays 0 and disarms.
5. Flags and trigger: trg_en=0b0010, intr_en=0b0001 -> trigger high one cycle, one cycle after the counter=comp1 rise; flag_clr[0] pulsed in the same cycle as a new rise -> flag[0] stays 1.
6. Reset mid-operation: drop rst while timer_out=1 -> immediately timer_out=inv, flags=0, active=FFFF; release with counter_value=FFFF -> no rise, no flag.
